// File: rtl/countdown_timer_if.sv
// countdown_timer_if: board-side signal bundle for the countdown timer.
// Carries the three conditioned pushbuttons (active-low), the minute preset
// switches, the six active-low seven-segment displays and the status flags.
// The board (or a bench) takes the master side; the timer takes the slave side.
interface countdown_timer_if;
    logic [3:1] key;
    logic [6:0] sw;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic       running;
    logic       done;

    modport master (
        output key, sw,
        input  hex0, hex1, hex2, hex3, hex4, hex5, running, done
    );

    modport slave (
        input  key, sw,
        output hex0, hex1, hex2, hex3, hex4, hex5, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss:cc countdown timer for the DE1-SoC board.
// KEY[1] loads min(SW,99) minutes, KEY[2] starts/pauses, KEY[3] acknowledges
// completion. The count is held as six BCD digits and decremented once per
// 10 ms tick while running. Displays and status flags are registered.
// rst_n is KEY[0]: asynchronous, active-low.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the display in DONE
// (25 ticks "0", 25 ticks blank, starting with "0").
module countdown_timer #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    countdown_timer_if.slave bus
);
    // One tick every 10 ms; the divider must be at least 2.
    localparam int TICK_DIV = CLK_HZ / 100;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [3:0]    m1, m0, s1, s0, c1, c0;
    logic [PW-1:0] prescaler;

    logic [3:1]    sync1, sync2, key_prev;
    logic [3:1]    press;

    logic          tick;
    logic          count_zero;
    logic          count_one;
    logic          blank;

    logic [6:0]    preset;
    logic [3:0]    preset_tens, preset_units;
    logic [3:0]    dec_m1, dec_m0, dec_s1, dec_s0, dec_c1, dec_c0;

    logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic          running_q, done_q;

`ifdef COUNTDOWN_BLINK_EN
    logic [4:0]    blink_ticks;
    logic          blink_off;
`endif

    // Active-low segment pattern for one BCD digit, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Two-flop synchronizer plus one history flop per button; idle level is 1.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            key_prev <= '1;
        end else begin
            sync1    <= bus.key;
            sync2    <= sync1;
            key_prev <= sync2;
        end
    end

    // A press is a high-to-low step of the synchronized level; holding gives one pulse.
    assign press = key_prev & ~sync2;

    assign tick       = (prescaler == TICK_LAST);
    assign count_zero = ({m1, m0, s1, s0, c1, c0} == 24'd0);
    assign count_one  = ({m1, m0, s1, s0, c1} == 20'd0) && (c0 == 4'd1);

    // Minute preset clamped to 99 and split into BCD tens/units.
    assign preset       = (bus.sw > 7'd99) ? 7'd99 : bus.sw;
    assign preset_tens  = 4'(preset / 7'd10);
    assign preset_units = 4'(preset % 7'd10);

`ifdef COUNTDOWN_BLINK_EN
    assign blank = (state == DONE) && blink_off;
`else
    assign blank = 1'b0;
`endif

    // Next count after one 10 ms decrement, with cc->ss->mm borrow chain.
    always_comb begin
        dec_m1 = m1;
        dec_m0 = m0;
        dec_s1 = s1;
        dec_s0 = s0;
        dec_c1 = c1;
        dec_c0 = c0;
        if (c0 != 4'd0) begin
            dec_c0 = c0 - 4'd1;
        end else begin
            dec_c0 = 4'd9;
            if (c1 != 4'd0) begin
                dec_c1 = c1 - 4'd1;
            end else begin
                dec_c1 = 4'd9;
                if (s0 != 4'd0) begin
                    dec_s0 = s0 - 4'd1;
                end else begin
                    dec_s0 = 4'd9;
                    if (s1 != 4'd0) begin
                        dec_s1 = s1 - 4'd1;
                    end else begin
                        dec_s1 = 4'd5;
                        if (m0 != 4'd0) begin
                            dec_m0 = m0 - 4'd1;
                        end else begin
                            dec_m0 = 4'd9;
                            dec_m1 = m1 - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Timer FSM, count, prescaler and registered display/status outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m1        <= '0;
            m0        <= '0;
            s1        <= '0;
            s0        <= '0;
            c1        <= '0;
            c0        <= '0;
            prescaler <= '0;
`ifdef COUNTDOWN_BLINK_EN
            blink_ticks <= '0;
            blink_off   <= 1'b0;
`endif
            hex0_q    <= 7'b1000000;
            hex1_q    <= 7'b1000000;
            hex2_q    <= 7'b1000000;
            hex3_q    <= 7'b1000000;
            hex4_q    <= 7'b1000000;
            hex5_q    <= 7'b1000000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (press[1]) begin
                state     <= IDLE;
                prescaler <= '0;
                m1        <= preset_tens;
                m0        <= preset_units;
                s1        <= '0;
                s0        <= '0;
                c1        <= '0;
                c0        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press[2]) begin
                            prescaler <= '0;
                            state     <= count_zero ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        // A pause in the same cycle as a tick wins; the prescaler is frozen.
                        if (press[2]) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            prescaler <= '0;
                            m1        <= dec_m1;
                            m0        <= dec_m0;
                            s1        <= dec_s1;
                            s0        <= dec_s0;
                            c1        <= dec_c1;
                            c0        <= dec_c0;
                            if (count_one) begin
                                state <= DONE;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (press[2]) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (!press[2] && press[3]) begin
                            state <= IDLE;
                        end
`ifdef COUNTDOWN_BLINK_EN
                        else if (tick) begin
                            prescaler <= '0;
                            if (blink_ticks == 5'd24) begin
                                blink_ticks <= '0;
                                blink_off   <= ~blink_off;
                            end else begin
                                blink_ticks <= blink_ticks + 5'd1;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end

`ifdef COUNTDOWN_BLINK_EN
            if (state != DONE) begin
                blink_ticks <= '0;
                blink_off   <= 1'b0;
            end
`endif

            hex5_q    <= blank ? 7'h7F : seg7(m1);
            hex4_q    <= blank ? 7'h7F : seg7(m0);
            hex3_q    <= blank ? 7'h7F : seg7(s1);
            hex2_q    <= blank ? 7'h7F : seg7(s0);
            hex1_q    <= blank ? 7'h7F : seg7(c1);
            hex0_q    <= blank ? 7'h7F : seg7(c0);
            running_q <= (state == RUN);
            done_q    <= (state == DONE);
        end
    end

    assign bus.hex0    = hex0_q;
    assign bus.hex1    = hex1_q;
    assign bus.hex2    = hex2_q;
    assign bus.hex3    = hex3_q;
    assign bus.hex4    = hex4_q;
    assign bus.hex5    = hex5_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: self-checking bench for countdown_timer.
// A remaining-time model (integer centiseconds) predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
// Compile with COUNTDOWN_BLINK_EN to match a blinking build.
module tb_countdown_timer;
    localparam int CLK_HZ = 500;
    localparam int T      = CLK_HZ / 100;

    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L2 = 7'b0100100;
    localparam logic [6:0] L4 = 7'b0011001;
    localparam logic [6:0] L5 = 7'b0010010;
    localparam logic [6:0] L7 = 7'b1111000;
    localparam logic [6:0] L8 = 7'b0000000;
    localparam logic [6:0] L9 = 7'b0010000;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   finished = 1'b0;

    mstate_t     m_state  = M_IDLE;
    int          rem      = 0;
    int          presc    = 0;
    int          done_age = 0;
    logic [3:1]  d1 = '1, d2 = '1, d3 = '1;
    logic [43:0] exp_vec = {{6{L0}}, 2'b00};

    always #5 clk = ~clk;

    countdown_timer_if bus ();

    countdown_timer #(.CLK_HZ(CLK_HZ)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Six displays for a remaining time given in centiseconds.
    function automatic logic [41:0] digits_of(input int r);
        int mm = r / 6000;
        int ss = (r / 100) % 60;
        int cc = r % 100;
        return {seg_of(mm / 10), seg_of(mm % 10), seg_of(ss / 10),
                seg_of(ss % 10), seg_of(cc / 10), seg_of(cc % 10)};
    endfunction

    function automatic logic [41:0] dut_hex();
        return {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    task automatic finish_test();
        if (!finished) begin
            finished = 1'b1;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
            if (n_fail >= 500) finish_test();
        end
    endtask

    task automatic check_reset(input string name);
        check_output({name, "_hex"}, 64'(dut_hex()), 64'({6{L0}}));
        check_output({name, "_running"}, 64'(bus.running), 64'(0));
        check_output({name, "_done"}, 64'(bus.done), 64'(0));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge: pull the selected buttons low for 'hold' cycles.
    task automatic press_keys(input logic [3:1] which, input int hold);
        bus.key = bus.key & ~which;
        wait_cycles(hold);
        bus.key = bus.key | which;
    endtask

    task automatic load_minutes(input logic [6:0] minutes);
        bus.sw = minutes;
        press_keys(3'b001, 2);
        wait_cycles(4);
    endtask

    // Called on a negedge: assert reset between clock edges and check at once.
    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1 check_reset(name);
        wait_cycles(2);
        rst_n = 1'b1;
    endtask

    // Reference model: presses act 3 edges after the pad; outputs show the previous edge's state.
    initial begin : model
        logic [3:1] pl;
        mstate_t    old;
        logic       blank;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state  = M_IDLE;
                rem      = 0;
                presc    = 0;
                done_age = 0;
                d1 = '1; d2 = '1; d3 = '1;
                exp_vec  = {{6{L0}}, 2'b00};
            end else begin
                pl = d3 & ~d2;
                d3 = d2; d2 = d1; d1 = bus.key;
                blank = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
                if (m_state == M_DONE && ((done_age / T) % 50) >= 25) blank = 1'b1;
`endif
                exp_vec = {blank ? {6{7'h7F}} : digits_of(rem),
                           m_state == M_RUN, m_state == M_DONE};
                old = m_state;
                if (pl[1]) begin
                    rem     = ((int'(bus.sw) > 99) ? 99 : int'(bus.sw)) * 6000;
                    presc   = 0;
                    m_state = M_IDLE;
                end else if (pl[2]) begin
                    case (m_state)
                        M_IDLE:  begin
                            presc   = 0;
                            m_state = (rem != 0) ? M_RUN : M_DONE;
                        end
                        M_RUN:   m_state = M_PAUSE;
                        M_PAUSE: m_state = M_RUN;
                        default: ;
                    endcase
                end else if (pl[3] && m_state == M_DONE) begin
                    m_state = M_IDLE;
                end else if (m_state == M_RUN) begin
                    if (presc == T - 1) begin
                        presc = 0;
                        rem   = rem - 1;
                        if (rem == 0) m_state = M_DONE;
                    end else begin
                        presc = presc + 1;
                    end
                end
                if (m_state == M_DONE) done_age = (old == M_DONE) ? done_age + 1 : 0;
            end
        end
    end

    // Every cycle out of reset, all outputs must equal the model's prediction.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && !finished)
                check_output("outputs", 64'({dut_hex(), bus.running, bus.done}), 64'(exp_vec));
        end
    end

    // Overall time limit.
    initial begin : watchdog
        #1_500_000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        finish_test();
    end

    // Directed scenarios followed by randomized button activity.
    initial begin : apply_stimulus
        int waited;
        int r;
        logic [3:1] keys;

        bus.key = 3'b111;
        bus.sw  = '0;
        #1 rst_n = 1'b0;
        #1 check_reset("reset_initial");
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        $display("[TB] load with clamp");
        load_minutes(7'd120);
        check_output("clamp_hex", 64'(dut_hex()), 64'({L9, L9, L0, L0, L0, L0}));
        check_output("clamp_running", 64'(bus.running), 64'(0));

        $display("[TB] borrow chain to done");
        load_minutes(7'd1);
        press_keys(3'b010, 4);
        wait_cycles(6);
        check_output("first_tick_hex", 64'(dut_hex()), 64'({L0, L0, L5, L9, L9, L9}));
        check_output("first_tick_running", 64'(bus.running), 64'(1));
        waited = 0;
        while (!bus.done && waited < 31000) begin
            @(negedge clk);
            waited++;
        end
        check_output("done_reached", 64'(bus.done), 64'(1));
        check_output("done_running", 64'(bus.running), 64'(0));
        check_output("done_hex", 64'(dut_hex()), 64'({6{L0}}));

        $display("[TB] acknowledge");
        press_keys(3'b100, 3);
        wait_cycles(3);
        check_output("ack_done", 64'(bus.done), 64'(0));

        $display("[TB] load on the terminal tick");
        load_minutes(7'd1);
        press_keys(3'b010, 4);
        wait_cycles(29996);
        bus.sw = 7'd2;
        press_keys(3'b001, 3);
        wait_cycles(4);
        check_output("terminal_load_done", 64'(bus.done), 64'(0));
        check_output("terminal_load_running", 64'(bus.running), 64'(0));
        check_output("terminal_load_hex", 64'(dut_hex()), 64'({L0, L2, L0, L0, L0, L0}));

        $display("[TB] pause and resume");
        load_minutes(7'd1);
        press_keys(3'b010, 4);
        wait_cycles(73);
        press_keys(3'b010, 4);
        wait_cycles(1000);
        check_output("pause_hex", 64'(dut_hex()), 64'({L0, L0, L5, L9, L8, L5}));
        check_output("pause_running", 64'(bus.running), 64'(0));
        press_keys(3'b010, 4);
        wait_cycles(3);
        check_output("resume_before_tick", 64'(bus.hex0), 64'(L5));
        wait_cycles(1);
        check_output("resume_after_tick", 64'(bus.hex0), 64'(L4));

        $display("[TB] zero start and blink");
        load_minutes(7'd0);
        press_keys(3'b010, 2);
        wait_cycles(4);
        check_output("zero_start_done", 64'(bus.done), 64'(1));
        check_output("zero_start_running", 64'(bus.running), 64'(0));
        wait_cycles(150);
`ifdef COUNTDOWN_BLINK_EN
        check_output("blink_phase_hex0", 64'(bus.hex0), 64'(7'h7F));
`else
        check_output("steady_done_hex0", 64'(bus.hex0), 64'(L0));
`endif
        wait_cycles(150);
        press_keys(3'b100, 2);
        wait_cycles(4);
        check_output("ack2_done", 64'(bus.done), 64'(0));
        check_output("ack2_hex", 64'(dut_hex()), 64'({6{L0}}));

        $display("[TB] load and start together");
        load_minutes(7'd3);
        press_keys(3'b010, 2);
        wait_cycles(20);
        bus.sw = 7'd7;
        press_keys(3'b011, 3);
        wait_cycles(4);
        check_output("together_running", 64'(bus.running), 64'(0));
        check_output("together_hex", 64'(dut_hex()), 64'({L0, L7, L0, L0, L0, L0}));

        $display("[TB] asynchronous reset mid-run");
        load_minutes(7'd2);
        press_keys(3'b010, 2);
        wait_cycles(37);
        async_reset("reset_midrun");
        wait_cycles(2);

        $display("[TB] randomized button activity");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1)
                bus.sw = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            r = int'($urandom_range(0, 9));
            if (r < 3)      keys = 3'b010;
            else if (r < 5) keys = 3'b001;
            else if (r < 7) keys = 3'b100;
            else            keys = 3'($urandom_range(1, 7));
            press_keys(keys, int'($urandom_range(1, 5)));
            wait_cycles(int'($urandom_range(1, 40)));
            if (i == 40) begin
                async_reset("reset_random");
                wait_cycles(2);
            end
        end

        wait_cycles(5);
        finish_test();
    end
endmodule
